instruction_sequencer: RTL

//  Program-driven instruction sequencer that produces the instruction word stream consumed by the master controller.
//  The host loads a program into local program memory and pulses start.
//  The block then issues one instruction per cycle, expands hardware loops and halts on a HALT word.

---
 rtl/instruction_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Program-driven instruction sequencer: issues one program word per cycle from local
// memory, expands nested hardware loops, and halts or faults into sticky status states.
module instruction_sequencer #(
  parameter int depth    = 2,
  parameter int W        = 16,
  parameter int insW     = (depth > 2) ? depth : 2,
  parameter int insD     = ((1 << depth) > W) ? (1 << depth) : W,
  parameter int insWidth = 4 + 2 + 2 * insW + insD,
  parameter int PA       = 8,
  parameter int LC       = 8,
  parameter int NEST     = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                progWrite,
  input  logic [PA-1:0]       progAddr,
  input  logic [insWidth-1:0] progData,
  input  logic                start,
  input  logic                abort,
  input  logic                stall,
  output logic [insWidth-1:0] instruction,
  output logic                insValid,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [PA-1:0]       pc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_ERROR} state_t;

  localparam logic [3:0] OP_NOP        = 4'b0101;
  localparam logic [3:0] OP_LOOP_BEGIN = 4'b1111;
  localparam logic [3:0] OP_LOOP_END   = 4'b1101;
  localparam logic [3:0] OP_HALT       = 4'b0111;
  localparam logic [insWidth-1:0] NOP_WORD = {OP_NOP, {(insWidth - 4){1'b0}}};
  localparam int SPW = $clog2(NEST + 1);

  logic [insWidth-1:0] mem [2**PA];

  state_t              state_q, state_d;
  logic [PA-1:0]       pc_q, pc_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic [PA-1:0]       stk_addr_q [NEST];
  logic [PA-1:0]       stk_addr_d [NEST];
  logic [LC-1:0]       stk_cnt_q  [NEST];
  logic [LC-1:0]       stk_cnt_d  [NEST];
  logic [insWidth-1:0] instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [insWidth-1:0] word;
  logic [3:0]          op;
  logic [LC-1:0]       n_eff;
  logic [PA-1:0]       top_addr;
  logic [LC-1:0]       top_cnt;
  logic                pc_last;

  assign word    = mem[pc_q];
  assign op      = word[insWidth-1 -: 4];
  assign n_eff   = (word[LC-1:0] == '0) ? LC'(1) : word[LC-1:0];
  assign pc_last = (pc_q == '1);

  always_comb begin
    top_addr = '0;
    top_cnt  = '0;
    for (int unsigned i = 0; i < NEST; i++) begin
      if (SPW'(i + 1) == sp_q) begin
        top_addr = stk_addr_q[i];
        top_cnt  = stk_cnt_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    stk_addr_d = stk_addr_q;
    stk_cnt_d  = stk_cnt_q;
    instr_d   = NOP_WORD;
    valid_d   = 1'b0;
    done_d    = done_q;
    error_d   = error_q;

    if (abort) begin
      state_d = S_IDLE;
      pc_d    = '0;
      sp_d    = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else if (start && state_q != S_RUN) begin
      state_d = S_RUN;
      pc_d    = '0;
      sp_d    = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else if (state_q == S_RUN && !stall) begin
      // Any step that would carry pc past the last address faults instead of wrapping.
      case (op)
        OP_LOOP_BEGIN: begin
          if (sp_q == SPW'(NEST) || pc_last) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < NEST; i++) begin
              if (SPW'(i) == sp_q) begin
                stk_addr_d[i] = pc_q + 1'b1;
                stk_cnt_d[i]  = n_eff;
              end
            end
            sp_d = sp_q + 1'b1;
            pc_d = pc_q + 1'b1;
          end
        end
        OP_LOOP_END: begin
          if (sp_q == '0) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (top_cnt > LC'(1)) begin
            for (int unsigned i = 0; i < NEST; i++) begin
              if (SPW'(i + 1) == sp_q) stk_cnt_d[i] = top_cnt - 1'b1;
            end
            pc_d = top_addr;
          end else if (pc_last) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            sp_d = sp_q - 1'b1;
            pc_d = pc_q + 1'b1;
          end
        end
        OP_HALT: begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end
        default: begin
          if (pc_last) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            instr_d = word;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
          end
        end
      endcase
    end

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      sp_q       <= '0;
      stk_addr_q <= '{default: '0};
      stk_cnt_q  <= '{default: '0};
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      stk_addr_q <= stk_addr_d;
      stk_cnt_q  <= stk_cnt_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Program memory is not reset; a write on the start edge lands before the first fetch.
  always_ff @(posedge CLK) begin
    if (progWrite && state_q != S_RUN) mem[progAddr] <= progData;
  end

  assign instruction = instr_q;
  assign insValid    = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign pc          = pc_q;

endmodule
